// File: rtl/kd_tree_pkg.sv
// Shared definitions for the kd-tree host controller: node command codes, widths and host FSM states.
package kd_tree_pkg;

    localparam int CMD_W  = 5;
    localparam int DATA_W = 24;

    localparam logic [CMD_W-1:0] CMD_NOP              = 5'h00;
    localparam logic [CMD_W-1:0] CMD_CENTER_FILL      = 5'h01;
    localparam logic [CMD_W-1:0] CMD_CENTER_FILL_DONE = 5'h05;
    localparam logic [CMD_W-1:0] CMD_BUSY             = 5'h08;
    localparam logic [CMD_W-1:0] CMD_START_SORTING    = 5'h09;
    localparam logic [CMD_W-1:0] CMD_SORT_DONE        = 5'h10;
    localparam logic [CMD_W-1:0] CMD_RST_DONE         = 5'h1E;
    localparam logic [CMD_W-1:0] CMD_RST              = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TREE_RST,
        ST_FILL,
        ST_WAIT_FILL,
        ST_SORT,
        ST_WAIT_SORT,
        ST_DONE,
        ST_ERROR
    } host_state_t;

    // States in which the shared wait timer runs.
    function automatic logic is_wait_state(input host_state_t s);
        return (s == ST_TREE_RST) || (s == ST_WAIT_FILL) || (s == ST_WAIT_SORT);
    endfunction

endpackage

// File: rtl/kd_wait_timer.sv
// Wait-state timer: synchronous clear, count enable and terminal-count flag for TC cycles.
module kd_wait_timer #(
    parameter int TC = 4096
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(TC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Flag fires during the TC-th enabled cycle so the caller leaves at that edge.
    assign o_tc = i_en && (r_cnt == CW'(TC - 1));

endmodule

// File: rtl/kd_tree_host_ctrl.sv
// Host initiator for the kd-tree root node: reset tree, stream centers, start sort, await completion.
// Optional cycle counters are enabled by defining KD_HOST_PERF_EN.
module kd_tree_host_ctrl #(
    parameter int CMD_W          = kd_tree_pkg::CMD_W,
    parameter int DATA_W         = kd_tree_pkg::DATA_W,
    parameter int MAX_CENTERS    = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [$clog2(MAX_CENTERS+1)-1:0]   num_centers,
    input  logic                               ctr_valid,
    input  logic [DATA_W-1:0]                  ctr_data,
    output logic                               ctr_ready,
    output logic [CMD_W-1:0]                   cmd_to_root,
    output logic [DATA_W-1:0]                  data_to_root,
    input  logic [CMD_W-1:0]                   cmd_from_root,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic                               overflow
`ifdef KD_HOST_PERF_EN
    ,
    output logic [31:0]                        perf_fill_cycles,
    output logic [31:0]                        perf_sort_cycles
`endif
);

    import kd_tree_pkg::*;

    localparam int NC_W = $clog2(MAX_CENTERS + 1);

    host_state_t       r_state;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_data;
    logic [NC_W-1:0]   r_num;
    logic [NC_W-1:0]   r_sent;
    logic              r_done;
    logic              r_error;
    logic              r_overflow;

    logic w_idle_like;
    logic w_start_acc;
    logic w_all_sent;
    logic w_fill_done;
    logic w_tmo;

    function automatic logic [NC_W-1:0] clamp_num(input logic [NC_W-1:0] n);
        return (n > NC_W'(MAX_CENTERS)) ? NC_W'(MAX_CENTERS) : n;
    endfunction

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_start_acc = start && !abort && w_idle_like;
    assign w_all_sent  = (r_sent >= r_num);
    assign w_fill_done = (cmd_from_root == CMD_CENTER_FILL_DONE);

    // Timer is held clear outside wait states; abort re-enters TREE_RST and must restart it.
    kd_wait_timer #(
        .TC (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (abort || !is_wait_state(r_state)),
        .i_en    (is_wait_state(r_state)),
        .o_tc    (w_tmo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cmd      <= CMD_NOP;
            r_data     <= '0;
            r_num      <= '0;
            r_sent     <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cmd  <= CMD_NOP;
            r_data <= '0;
            if (abort) begin
                r_state    <= ST_TREE_RST;
                r_cmd      <= CMD_RST;
                r_sent     <= '0;
                r_error    <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start) begin
                            r_num      <= clamp_num(num_centers);
                            r_sent     <= '0;
                            r_error    <= 1'b0;
                            r_overflow <= 1'b0;
                            r_state    <= ST_TREE_RST;
                            r_cmd      <= CMD_RST;
                        end
                    end
                    ST_TREE_RST: begin
                        if (cmd_from_root == CMD_RST_DONE) begin
                            r_state <= ST_FILL;
                        end else if (w_tmo) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_cmd <= CMD_RST;
                        end
                    end
                    ST_FILL: begin
                        if (w_fill_done && !w_all_sent) begin
                            r_overflow <= 1'b1;
                            r_state    <= ST_SORT;
                        end else if (w_all_sent) begin
                            r_state <= w_fill_done ? ST_SORT : ST_WAIT_FILL;
                        end else if (ctr_valid) begin
                            r_cmd  <= CMD_CENTER_FILL;
                            r_data <= ctr_data;
                            r_sent <= r_sent + 1'b1;
                        end
                    end
                    ST_WAIT_FILL: begin
                        if (w_fill_done) begin
                            r_state <= ST_SORT;
                        end else if (w_tmo) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                    ST_SORT: begin
                        r_cmd   <= CMD_START_SORTING;
                        r_state <= ST_WAIT_SORT;
                    end
                    ST_WAIT_SORT: begin
                        if (cmd_from_root == CMD_SORT_DONE) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_tmo) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ctr_ready    = (r_state == ST_FILL) && ctr_valid && !w_all_sent && !w_fill_done;
    assign cmd_to_root  = r_cmd;
    assign data_to_root = r_data;
    assign busy         = !w_idle_like;
    assign done         = r_done;
    assign error        = r_error;
    assign overflow     = r_overflow;

`ifdef KD_HOST_PERF_EN
    logic [31:0] r_perf_fill;
    logic [31:0] r_perf_sort;

    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_perf_fill <= '0;
            r_perf_sort <= '0;
        end else begin
            if (((r_state == ST_FILL) || (r_state == ST_WAIT_FILL)) && (r_perf_fill != '1)) begin
                r_perf_fill <= r_perf_fill + 1'b1;
            end
            if (((r_state == ST_SORT) || (r_state == ST_WAIT_SORT)) && (r_perf_sort != '1)) begin
                r_perf_sort <= r_perf_sort + 1'b1;
            end
        end
    end

    assign perf_fill_cycles = r_perf_fill;
    assign perf_sort_cycles = r_perf_sort;
`endif

endmodule

// File: tb/tb_kd_tree_host_ctrl.sv
// Directed self-checking bench for kd_tree_host_ctrl; the root node is played by the stimulus sequence.
module tb_kd_tree_host_ctrl;

    localparam int CW   = 5;
    localparam int DW   = 24;
    localparam int MAXC = 32;
    localparam int TMO  = 16;
    localparam int NCW  = 6;

    localparam logic [CW-1:0] NOP = 5'h00;
    localparam logic [CW-1:0] CF  = 5'h01;
    localparam logic [CW-1:0] CFD = 5'h05;
    localparam logic [CW-1:0] BSY = 5'h08;
    localparam logic [CW-1:0] SS  = 5'h09;
    localparam logic [CW-1:0] SD  = 5'h10;
    localparam logic [CW-1:0] RD  = 5'h1E;
    localparam logic [CW-1:0] RST = 5'h1F;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic [NCW-1:0] num_centers;
    logic           ctr_valid;
    logic [DW-1:0]  ctr_data;
    logic           ctr_ready;
    logic [CW-1:0]  cmd_to_root;
    logic [DW-1:0]  data_to_root;
    logic [CW-1:0]  cmd_from_root;
    logic           busy;
    logic           done;
    logic           error;
    logic           overflow;
`ifdef KD_HOST_PERF_EN
    logic [31:0]    perf_fill_cycles;
    logic [31:0]    perf_sort_cycles;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int hs;
    int nrst;

    logic [DW-1:0] fd [6] = '{24'hA1B2C3, 24'h000000, 24'h123456, 24'hFFFFFF, 24'h000001, 24'h5A5A5A};
    logic          fv [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic          fr [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    kd_tree_host_ctrl #(
        .CMD_W          (CW),
        .DATA_W         (DW),
        .MAX_CENTERS    (MAXC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .num_centers   (num_centers),
        .ctr_valid     (ctr_valid),
        .ctr_data      (ctr_data),
        .ctr_ready     (ctr_ready),
        .cmd_to_root   (cmd_to_root),
        .data_to_root  (data_to_root),
        .cmd_from_root (cmd_from_root),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .overflow      (overflow)
`ifdef KD_HOST_PERF_EN
        ,
        .perf_fill_cycles (perf_fill_cycles),
        .perf_sort_cycles (perf_sort_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_centers = '0;
        ctr_valid = 1'b0; ctr_data = '0; cmd_from_root = NOP;
        tick(); tick();
        reset = 1'b0;
        ctr_valid = 1'b1;
        #1;
        chk("rst_cmd", 32'(cmd_to_root), 32'(NOP));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ctr_ready), 32'd0);
        chk("rst_err_ovf_done", 32'({error, overflow, done}), 32'd0);
        ctr_valid = 1'b0;

        // Nominal job, 4 centers with one bubble
        num_centers = 6'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("nom_rst_cmd", 32'(cmd_to_root), 32'(RST));
        chk("nom_busy", 32'(busy), 32'd1);
        cmd_from_root = BSY;
        tick(); tick();
        chk("nom_rst_hold", 32'(cmd_to_root), 32'(RST));
        cmd_from_root = RD;
        tick();
        cmd_from_root = NOP;
        chk("nom_fill_entry_cmd", 32'(cmd_to_root), 32'(NOP));
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            ctr_valid = fv[i]; ctr_data = fd[i];
            #1;
            chk("nom_ready", 32'(ctr_ready), 32'(fr[i]));
            if (ctr_ready && ctr_valid) hs++;
            tick();
            chk("nom_fill_cmd", 32'(cmd_to_root), fr[i] ? 32'(CF) : 32'(NOP));
            if (fr[i]) chk("nom_fill_data", 32'(data_to_root), 32'(fd[i]));
        end
        ctr_valid = 1'b0;
        chk("nom_handshakes", 32'(hs), 32'd4);
        cmd_from_root = CFD;
        tick();
        cmd_from_root = NOP;
        chk("nom_pre_sort", 32'(cmd_to_root), 32'(NOP));
        tick();
        chk("nom_start_sort", 32'(cmd_to_root), 32'(SS));
        chk("nom_start_sort_data", 32'(data_to_root), 32'd0);
        tick();
        chk("nom_sort_one_beat", 32'(cmd_to_root), 32'(NOP));
        chk("nom_busy_wait_sort", 32'(busy), 32'd1);
        cmd_from_root = SD;
        tick();
        cmd_from_root = NOP;
        chk("nom_done_pulse", 32'(done), 32'd1);
        chk("nom_busy_done", 32'(busy), 32'd0);
        tick();
        chk("nom_done_width", 32'(done), 32'd0);

        // Overflow: 8 requested, fill done after 5
        num_centers = 6'd8; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_rst_cmd", 32'(cmd_to_root), 32'(RST));
        cmd_from_root = RD;
        tick();
        cmd_from_root = NOP;
        hs = 0;
        ctr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ctr_data = 24'(i + 16);
            #1;
            if (ctr_ready) hs++;
            tick();
        end
        cmd_from_root = CFD;
        #1;
        chk("ovf_ready_low", 32'(ctr_ready), 32'd0);
        tick();
        cmd_from_root = NOP;
        ctr_valid = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_handshakes", 32'(hs), 32'd5);
        tick();
        chk("ovf_start_sort", 32'(cmd_to_root), 32'(SS));

        // Abort during WAIT_SORT reuses latched count of 8
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cmd", 32'(cmd_to_root), 32'(RST));
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ovf_clr", 32'(overflow), 32'd0);
        cmd_from_root = RD;
        tick();
        cmd_from_root = NOP;
        hs = 0;
        ctr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ctr_data = 24'(i);
            #1;
            if (ctr_ready) hs++;
            tick();
        end
        ctr_valid = 1'b0;
        chk("abort_reuse_num", 32'(hs), 32'd8);
        cmd_from_root = CFD;
        tick();
        cmd_from_root = NOP;
        tick();
        chk("abort_start_sort", 32'(cmd_to_root), 32'(SS));
        cmd_from_root = SD;
        tick();
        cmd_from_root = NOP;
        chk("abort_done", 32'(done), 32'd1);

        // Timeout in TREE_RST
        num_centers = 6'd2; start = 1'b1;
        tick();
        start = 1'b0;
        nrst = 0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_to_root !== RST) break;
            nrst++;
            tick();
        end
        chk("tmo_rst_cycles", 32'(nrst), 32'(TMO));
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_cmd", 32'(cmd_to_root), 32'(NOP));
        chk("tmo_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo_restart_err", 32'(error), 32'd0);
        chk("tmo_restart_cmd", 32'(cmd_to_root), 32'(RST));

        // Reset mid-FILL
        cmd_from_root = RD;
        tick();
        cmd_from_root = NOP;
        ctr_valid = 1'b1; ctr_data = 24'h111111;
        tick();
        chk("midfill_cf", 32'(cmd_to_root), 32'(CF));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midfill_rst_cmd", 32'(cmd_to_root), 32'(NOP));
        chk("midfill_rst_busy", 32'(busy), 32'd0);
        chk("midfill_rst_ready", 32'(ctr_ready), 32'd0);
        chk("midfill_rst_err", 32'(error), 32'd0);

        // num_centers == 0
        num_centers = 6'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_rst_cmd", 32'(cmd_to_root), 32'(RST));
        cmd_from_root = RD;
        tick();
        cmd_from_root = NOP;
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ctr_ready) hs++;
            tick();
            chk("zero_nop", 32'(cmd_to_root), 32'(NOP));
        end
        chk("zero_no_ready", 32'(hs), 32'd0);
        ctr_valid = 1'b0;
        cmd_from_root = CFD;
        tick();
        cmd_from_root = NOP;
        tick();
        chk("zero_start_sort", 32'(cmd_to_root), 32'(SS));
        cmd_from_root = SD;
        tick();
        cmd_from_root = NOP;
        chk("zero_done", 32'(done), 32'd1);

        // Clamp 40 -> 32
        num_centers = 6'd40; start = 1'b1;
        tick();
        start = 1'b0;
        cmd_from_root = RD;
        tick();
        cmd_from_root = NOP;
        hs = 0;
        ctr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ctr_data = 24'(i);
            #1;
            if (ctr_ready) hs++;
            tick();
        end
        ctr_valid = 1'b0;
        chk("clamp_handshakes", 32'(hs), 32'(MAXC));

        // start + abort together in IDLE: abort path, num not latched
        reset = 1'b1;
        tick();
        reset = 1'b0;
        num_centers = 6'd5; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_cmd", 32'(cmd_to_root), 32'(RST));
        chk("sa_busy", 32'(busy), 32'd1);
        cmd_from_root = RD;
        tick();
        cmd_from_root = NOP;
        ctr_valid = 1'b1;
        #1;
        chk("sa_abort_path_ready", 32'(ctr_ready), 32'd0);
        tick();
        chk("sa_abort_path_cmd", 32'(cmd_to_root), 32'(NOP));
        ctr_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
